// File: rtl/camera_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : camera_capture_sequencer_if
// Description : Pixel FIFO write port between the capture sequencer and the
//               pixel FIFO.
//               Signals:
//                 fifo_wr_en   - write enable, driven by the sequencer
//                 fifo_wr_data - 16-bit write word, driven by the sequencer
//                 fifo_full    - FIFO cannot accept a write this cycle
//               Modports:
//                 master - the sequencer (writer)
//                 slave  - the FIFO (reader)
// Revision    : 1.0 - initial release
// ============================================================================
interface camera_capture_sequencer_if;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        fifo_full;

    modport master (
        output fifo_wr_en,
        output fifo_wr_data,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr_en,
        input  fifo_wr_data,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/camera_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : camera_capture_sequencer
// Description : Builds one composite image over several frames. Each frame
//               keeps one Bayer-preserving line pair per LINE_STRIDE lines
//               (the current phase) and streams a header word plus pixel
//               words for every kept line into the pixel FIFO. A phase that
//               loses a word or sees a short line is retried next frame.
// Ports       : clk, reset_n       - clock, async active-low reset
//               request_image      - start a capture (ignored while busy)
//               abort              - cancel the capture immediately
//               frame_start/_end   - synced FV edges (1-cycle pulses)
//               line_start/_end    - synced LV edges (1-cycle pulses)
//               pixel_sample       - pixel_data is valid this cycle
//               pixel_data[11:0]   - synced pixel value
//               fifo               - FIFO write port (master modport)
//               busy               - not in IDLE
//               image_started      - pulse on first frame of a capture
//               image_finished     - pulse when a capture ends
//               capture_error      - sticky error until next request
//               frames_used[7:0]   - frames consumed by the capture
// Revision    : 1.0 - initial release
// ============================================================================
module camera_capture_sequencer #(
    parameter int PIXELS_PER_LINE = 2592,
    parameter int LINES_PER_FRAME = 1944,
    parameter int LINE_STRIDE     = 16,
    parameter int MAX_FRAMES      = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              request_image,
    input  logic                              abort,
    input  logic                              frame_start,
    input  logic                              frame_end,
    input  logic                              line_start,
    input  logic                              line_end,
    input  logic                              pixel_sample,
    input  logic [11:0]                       pixel_data,
    camera_capture_sequencer_if.master        fifo,
    output logic                              busy,
    output logic                              image_started,
    output logic                              image_finished,
    output logic                              capture_error,
    output logic [7:0]                        frames_used
);

    localparam int                c_phases     = LINE_STRIDE / 2;
    localparam int                c_ph_w       = $clog2(c_phases);
    localparam logic [c_ph_w-1:0] c_last_phase = c_ph_w'(c_phases - 1);
    localparam logic [12:0]       c_lines      = 13'(LINES_PER_FRAME);
    localparam logic [12:0]       c_pixels     = 13'(PIXELS_PER_LINE);
    localparam logic [7:0]        c_max_frames = 8'(MAX_FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_ph_w-1:0]  r_phase;
    logic [7:0]         r_frames_used;
    logic [11:0]        r_line_idx;
    logic [11:0]        r_pix_cnt;
    logic               r_frame_fail;
    logic               r_capture_error;
    logic               r_image_started;
    logic               r_wr_en;
    logic [15:0]        r_wr_data;

    logic w_start_capture;
    logic w_frame_begin;
    logic w_phase_adv;
    logic w_err_budget;

    // Keep pattern: line pairs cycle through the phases; since the stride is
    // a power of two the modulo reduces to a bit slice of the pair index.
    logic w_active;
    logic w_kept;
    logic w_line_room;
    logic w_hdr;
    logic w_pix;
    logic w_want;
    logic w_write;
    logic w_drop;
    logic w_short;

    assign w_active    = (r_state == STREAM) && !abort && !w_frame_begin;
    assign w_kept      = (r_line_idx[c_ph_w:1] == r_phase) &&
                         ({1'b0, r_line_idx} < c_lines);
    assign w_line_room = ({1'b0, r_pix_cnt} < c_pixels);
    assign w_hdr       = w_active && line_start && w_kept;
    // A pixel coincident with line_start cannot belong to the new line.
    assign w_pix       = w_active && pixel_sample && !line_start && w_kept && w_line_room;
    assign w_want      = w_hdr || w_pix;
    assign w_write     = w_want && !fifo.fifo_full;
    assign w_drop      = w_want && fifo.fifo_full;
    assign w_short     = w_active && line_end && w_kept && w_line_room;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_start_capture = 1'b0;
        w_frame_begin   = 1'b0;
        w_phase_adv     = 1'b0;
        w_err_budget    = 1'b0;
        if (abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (request_image) begin
                        w_state_next    = ARMED;
                        w_start_capture = 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        w_state_next  = STREAM;
                        w_frame_begin = 1'b1;
                    end
                end
                STREAM: begin
                    // A frame_start here means frame_end was missed: the
                    // running frame is discarded and a fresh one begins.
                    if (frame_start) begin
                        if (r_frames_used == c_max_frames) begin
                            w_state_next = DONE;
                            w_err_budget = 1'b1;
                        end else begin
                            w_frame_begin = 1'b1;
                        end
                    end else if (frame_end) begin
                        w_phase_adv = !r_frame_fail;
                        if (!r_frame_fail && (r_phase == c_last_phase)) begin
                            w_state_next = DONE;
                        end else if (r_frames_used == c_max_frames) begin
                            w_state_next = DONE;
                            w_err_budget = 1'b1;
                        end else begin
                            w_state_next = ARMED;
                        end
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, error tracking and registered FIFO write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase         <= '0;
            r_frames_used   <= 8'd0;
            r_line_idx      <= 12'd0;
            r_pix_cnt       <= 12'd0;
            r_frame_fail    <= 1'b0;
            r_capture_error <= 1'b0;
            r_image_started <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_data       <= 16'd0;
        end else begin
            r_image_started <= 1'b0;
            r_wr_en         <= w_write;
            if (w_write) begin
                r_wr_data <= w_hdr ? {4'hC, r_line_idx} : {4'h0, pixel_data};
            end

            if (w_start_capture) begin
                r_capture_error <= 1'b0;
                r_frames_used   <= 8'd0;
                r_phase         <= '0;
            end

            if (w_frame_begin) begin
                r_frames_used   <= r_frames_used + 8'd1;
                r_line_idx      <= 12'd0;
                r_pix_cnt       <= 12'd0;
                r_frame_fail    <= 1'b0;
                r_image_started <= (r_state == ARMED) && (r_frames_used == 8'd0);
            end else if (w_active) begin
                if (line_end && (r_line_idx != 12'hFFF)) begin
                    r_line_idx <= r_line_idx + 12'd1;
                end
                if (line_start) begin
                    r_pix_cnt <= 12'd0;
                end else if (w_pix) begin
                    // Counts consumed pixels, including ones lost to a full FIFO.
                    r_pix_cnt <= r_pix_cnt + 12'd1;
                end
                if (w_drop || w_short) begin
                    r_frame_fail    <= 1'b1;
                    r_capture_error <= 1'b1;
                end
            end

            if (w_phase_adv) begin
                r_phase <= r_phase + 1'b1;
            end
            if (w_err_budget) begin
                r_capture_error <= 1'b1;
            end
        end
    end

    assign fifo.fifo_wr_en   = r_wr_en;
    assign fifo.fifo_wr_data = r_wr_data;
    assign busy              = (r_state != IDLE);
    assign image_started     = r_image_started;
    assign image_finished    = (r_state == DONE);
    assign capture_error     = r_capture_error;
    assign frames_used       = r_frames_used;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_capture_sequencer
// Description : Self-checking bench for camera_capture_sequencer. Two DUTs:
//               dut1 (MAX_FRAMES=32) for capture/retry/abort scenarios and
//               dut2 (MAX_FRAMES=2, FIFO permanently full) for the frame
//               budget. Expected FIFO words are queued ahead of stimulus and
//               a monitor pops and compares each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_capture_sequencer;

    localparam int PPL    = 4;
    localparam int LPF    = 8;
    localparam int STRIDE = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        request_image = 1'b0;
    logic        request2 = 1'b0;
    logic        abort = 1'b0;
    logic        abort2 = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        line_start = 1'b0;
    logic        line_end = 1'b0;
    logic        pixel_sample = 1'b0;
    logic [11:0] pixel_data = 12'd0;

    logic        busy1, started1, finished1, err1;
    logic [7:0]  used1;
    logic        busy2, started2, finished2, err2;
    logic [7:0]  used2;

    camera_capture_sequencer_if bus1 ();
    camera_capture_sequencer_if bus2 ();

    assign bus2.fifo_full = 1'b1;

    always #5 clk = ~clk;

    camera_capture_sequencer #(
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .LINE_STRIDE     (STRIDE),
        .MAX_FRAMES      (32)
    ) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .request_image  (request_image),
        .abort          (abort),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .line_start     (line_start),
        .line_end       (line_end),
        .pixel_sample   (pixel_sample),
        .pixel_data     (pixel_data),
        .fifo           (bus1),
        .busy           (busy1),
        .image_started  (started1),
        .image_finished (finished1),
        .capture_error  (err1),
        .frames_used    (used1)
    );

    camera_capture_sequencer #(
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .LINE_STRIDE     (STRIDE),
        .MAX_FRAMES      (2)
    ) dut2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .request_image  (request2),
        .abort          (abort2),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .line_start     (line_start),
        .line_end       (line_end),
        .pixel_sample   (pixel_sample),
        .pixel_data     (pixel_data),
        .fifo           (bus2),
        .busy           (busy2),
        .image_started  (started2),
        .image_finished (finished2),
        .capture_error  (err2),
        .frames_used    (used2)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          tag = 0;
    int          last_fe = 0;
    int          fin1_cnt = 0;
    int          fin1_cyc = -1;
    int          fin2_cnt = 0;
    int          fin2_cyc = -1;
    int          st1_cnt = 0;
    logic [15:0] sbq[$];

    always @(posedge clk) cyc++;

    // Monitor: compares every FIFO write against the scoreboard queue.
    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (bus1.fifo_wr_en) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got=%h required=no write (cyc %0d)", bus1.fifo_wr_data, cyc);
            end else begin
                exp_w = sbq.pop_front();
                if (bus1.fifo_wr_data !== exp_w) begin
                    bad++;
                    $display("FAIL wr_data: got=%h required=%h (cyc %0d)", bus1.fifo_wr_data, exp_w, cyc);
                end
            end
        end
        if (bus2.fifo_wr_en) begin
            total++;
            bad++;
            $display("FAIL dut2_wr: got=%h required=no write (fifo full)", bus2.fifo_wr_data);
        end
        if (finished1) begin fin1_cnt++; fin1_cyc = cyc; end
        if (finished2) begin fin2_cnt++; fin2_cyc = cyc; end
        if (started1)  st1_cnt++;
    end

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pv(input int line, input int p);
        return 12'((tag << 8) | (line << 4) | p);
    endfunction

    // Queue the words of one kept line: header, then npix pixels minus skip.
    task automatic exp_line(input int line, input int npix, input int skip);
        sbq.push_back(16'hC000 | 16'(line));
        for (int p = 0; p < npix; p++) begin
            if (p != skip) sbq.push_back({4'h0, pv(line, p)});
        end
    endtask

    // Stride 4: phase 0 keeps lines 0,1,4,5; phase 1 keeps 2,3,6,7.
    task automatic exp_phase(input int ph);
        exp_line(ph * 2,     PPL, -1);
        exp_line(ph * 2 + 1, PPL, -1);
        exp_line(ph * 2 + 4, PPL, -1);
        exp_line(ph * 2 + 5, PPL, -1);
    endtask

    task automatic req1();
        request_image = 1'b1;
        tick();
        request_image = 1'b0;
    endtask

    task automatic send_frame(input int short_line, input int full_line, input int full_pix,
                              input int req_line, input int abort_line, input int abort_pix);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        for (int l = 0; l < LPF; l++) begin
            int n;
            if (l == req_line) req1();
            n = (l == short_line) ? PPL - 1 : PPL;
            line_start = 1'b1;
            tick();
            line_start = 1'b0;
            repeat (3) tick();
            for (int p = 0; p < n; p++) begin
                pixel_data    = pv(l, p);
                pixel_sample  = 1'b1;
                bus1.fifo_full = (l == full_line) && (p == full_pix);
                abort         = (l == abort_line) && (p == abort_pix);
                tick();
                pixel_sample  = 1'b0;
                bus1.fifo_full = 1'b0;
                abort         = 1'b0;
                tick();
            end
            line_end = 1'b1;
            tick();
            line_end = 1'b0;
            tick();
        end
        frame_end = 1'b1;
        last_fe   = cyc;
        tick();
        frame_end = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus1.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     int'(busy1), 0);
        chk("rst_wr_en",    int'(bus1.fifo_wr_en), 0);
        chk("rst_used",     int'(used1), 0);
        chk("rst_err",      int'(err1), 0);
        chk("rst_finished", int'(finished1), 0);
        chk("rst_started",  int'(started1), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Clean two-phase capture, then a third frame that must be ignored.
        tag = 1;
        req1();
        chk("clean_busy_armed", int'(busy1), 1);
        exp_phase(0);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("clean_started", st1_cnt, 1);
        chk("clean_used_f1", int'(used1), 1);
        tag = 2;
        exp_phase(1);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("clean_fin_cnt", fin1_cnt, 1);
        chk("clean_fin_lat", fin1_cyc, last_fe + 1);
        chk("clean_used",    int'(used1), 2);
        chk("clean_err",     int'(err1), 0);
        chk("clean_idle",    int'(busy1), 0);
        tag = 3;
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("clean_f3_nowr", sbq.size(), 0);

        // FIFO full on the second pixel of line 0: phase 0 retried.
        tag = 4;
        req1();
        chk("full_used_clr", int'(used1), 0);
        exp_line(0, PPL, 1);
        exp_line(1, PPL, -1);
        exp_line(4, PPL, -1);
        exp_line(5, PPL, -1);
        send_frame(-1, 0, 1, -1, -1, -1);
        chk("full_err",  int'(err1), 1);
        chk("full_busy", int'(busy1), 1);
        tag = 5;
        exp_phase(0);
        send_frame(-1, -1, -1, -1, -1, -1);
        tag = 6;
        exp_phase(1);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("full_used",    int'(used1), 3);
        chk("full_fin_cnt", fin1_cnt, 2);
        chk("full_err_end", int'(err1), 1);

        // Short kept line (line 1 has 3 pixels): phase 0 retried.
        tag = 7;
        req1();
        chk("short_err_clr", int'(err1), 0);
        exp_line(0, PPL, -1);
        exp_line(1, PPL - 1, -1);
        exp_line(4, PPL, -1);
        exp_line(5, PPL, -1);
        send_frame(1, -1, -1, -1, -1, -1);
        chk("short_err", int'(err1), 1);
        tag = 8;
        exp_phase(0);
        send_frame(-1, -1, -1, -1, -1, -1);
        tag = 9;
        exp_phase(1);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("short_used",    int'(used1), 3);
        chk("short_fin_cnt", fin1_cnt, 3);

        // Request in the middle of a frame: nothing until the next frame.
        tag = 10;
        send_frame(-1, -1, -1, 2, -1, -1);
        chk("mid_busy",      int'(busy1), 1);
        chk("mid_no_start",  st1_cnt, 3);
        chk("mid_used",      int'(used1), 0);
        tag = 11;
        exp_phase(0);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("mid_started",   st1_cnt, 4);
        tag = 12;
        exp_phase(1);
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("mid_fin_cnt",   fin1_cnt, 4);
        chk("mid_used_end",  int'(used1), 2);

        // Abort on pixel 2 of line 1: that pixel and everything after is dropped.
        tag = 13;
        req1();
        exp_line(0, PPL, -1);
        exp_line(1, 2, -1);
        send_frame(-1, -1, -1, -1, 1, 2);
        chk("abort_busy",    int'(busy1), 0);
        chk("abort_no_fin",  fin1_cnt, 4);
        chk("abort_sb",      sbq.size(), 0);

        // Frame budget of 2 with the FIFO stuck full.
        request2 = 1'b1;
        tick();
        request2 = 1'b0;
        tag = 14;
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("budget_busy_f1", int'(busy2), 1);
        tag = 15;
        send_frame(-1, -1, -1, -1, -1, -1);
        chk("budget_fin_cnt", fin2_cnt, 1);
        chk("budget_fin_lat", fin2_cyc, last_fe + 1);
        chk("budget_err",     int'(err2), 1);
        chk("budget_used",    int'(used2), 2);
        chk("budget_idle",    int'(busy2), 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_capture_sequencer.md
Name: camera_capture_sequencer

Overview:
- Transaction controller that sits downstream of the camera sensor front-end synchroniser.
- Turns one image request into a composite image built over several frames. Each frame contributes one Bayer-preserving line-pair phase: keep 2 lines, skip STRIDE-2.
- Drives the pixel FIFO write port with per-line header words and pixel words.
- Retries a phase in the next frame when a line is lost to FIFO-full or a short line; the scene is static.

Parameters:
- PIXELS_PER_LINE, 2592, valid pixels written per kept line.
- LINES_PER_FRAME, 1944, lines at or above this index are never kept.
- LINE_STRIDE, 16, line period of the keep pattern; power of two, ≥4; phases = LINE_STRIDE/2.
- MAX_FRAMES, 32, frame budget per image, retries included (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- request_image  in  1  start capture (pulse; ignored while busy)
- abort  in  1  cancel capture (pulse)
- frame_start  in  1  1-cycle pulse, synced FV rise
- frame_end  in  1  1-cycle pulse, synced FV fall
- line_start  in  1  1-cycle pulse, synced LV rise
- line_end  in  1  1-cycle pulse, synced LV fall
- pixel_sample  in  1  1-cycle pulse, pixel_data valid now
- pixel_data  in  12  synced pixel value
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  16  FIFO write word
- busy  out  1  high in any state except IDLE
- image_started  out  1  1-cycle pulse, first frame of capture began
- image_finished  out  1  1-cycle pulse, capture ended (success or budget exhausted)
- capture_error  out  1  sticky until next request_image: a word was dropped, a line was short, or the budget ran out
- frames_used  out  8  frames consumed by current/last capture

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, ARMED, STREAM, DONE.
  - IDLE: request_image → ARMED; clears capture_error, frames_used and phase.
  - ARMED: waits for frame_start; never joins a frame mid-flight. On frame_start → STREAM; image_started pulses on the first frame only; frames_used++; line_idx, frame_fail ← 0.
  - STREAM on frame_end, normal case: if frame_fail is 0, phase++. If phase was LINE_STRIDE/2-1 → DONE, else → ARMED.
  - STREAM on frame_end, budget exhausted: if frames_used == MAX_FRAMES and not finishing → DONE with capture_error set.
  - frame_start while in STREAM (frame_end missed): current frame counts as failed, phase not advanced. Treated as a new frame start: frames_used++, counters reset, stay in STREAM. If frames_used already equals MAX_FRAMES → DONE with error.
  - DONE: one cycle; image_finished = 1; → IDLE.
  - abort in any state → IDLE next cycle; no image_finished; FIFO writes stop immediately; abort wins over any simultaneous event.
- Line tracking in STREAM:
  - line_idx (12b) increments on each line_end and saturates at 4095.
  - Line kept iff (line_idx >> 1) mod (LINE_STRIDE/2) == phase and line_idx < LINES_PER_FRAME.
  - pix_cnt (12b) resets on line_start.
- Writes are registered, latency 1 cycle after the triggering pulse:
  - line_start on a kept line → header {4'hC, line_idx}.
  - pixel_sample on a kept line with pix_cnt < PIXELS_PER_LINE → {4'h0, pixel_data}; pix_cnt++.
  - Extra pixels beyond PIXELS_PER_LINE are ignored silently.
  - pixel_sample in the same cycle as line_start is dropped; the front-end guarantees ≥4 cycles between them.
- FIFO full: fifo_full sampled in the trigger cycle. If high, no write occurs, the word is lost, and capture_error and frame_fail are set.
- Short line: line_end on a kept line with pix_cnt < PIXELS_PER_LINE sets frame_fail and capture_error.
- A retried phase re-emits all lines of that phase. The consumer de-duplicates by header line number.
- Pulses outside STREAM are ignored. request_image while busy is ignored.

Test Plan:
- Clean capture, PIXELS_PER_LINE=4, LINES_PER_FRAME=8, LINE_STRIDE=4: request, then 3 frames of 8 lines × 4 pixels. Required: frame1 writes headers C000, C001, C004, C005, each followed by 4 pixels; frame2 writes C002, C003, C006, C007; image_finished pulses 1 cycle after frame2 frame_end; frames_used=2; capture_error=0; frame3 produces no writes.
- fifo_full held during the second pixel of line 0 in frame1: capture_error=1; frame2 repeats phase 0 (C000…); finish after frame3; frames_used=3.
- Kept line with only 3 pixels before line_end: same retry behaviour as the FIFO-full case; frames_used=3.
- request_image mid-frame: no writes until next frame_start; image_started pulses on that frame_start.
- abort during pixel 2 of line 1: fifo_wr_en=0 from next cycle; busy=0; no image_finished.
- MAX_FRAMES=2 with fifo_full stuck high: after frame2's frame_end, image_finished=1, capture_error=1, frames_used=2.
